// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle 64-bit doubleword memory with valid/ready request and response channels.
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 2,
  parameter int ADDR_W = 64
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0] wdata_q, rdata_q;
  logic err_q;
  logic [63:0] mem [DEPTH_WORDS];
  logic [IW-1:0] idx;
  logic oor, mis, commit;
  assign idx = addr_q[IW+2:3];
  assign oor = |(addr_q >> (IW + 3));
`ifdef MEM_ALIGN_CHECK_EN
  assign mis = |addr_q[2:0];
`else
  assign mis = 1'b0 & (|addr_q[2:0]);
`endif
  // The access lands on the edge that moves WAIT into RESP; a reset on that edge abandons it.
  assign commit = state_q == WAIT && cnt_q == '0 && !resetl;
  assign req_ready = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = rdata_q;
  assign resp_err = err_q;
  // Next state: the counter is loaded on acceptance so RESP is entered exactly LATENCY edges later.
  always_comb begin
    state_d = state_q == IDLE ? (req_valid ? WAIT : IDLE) :
              state_q == WAIT ? (cnt_q == '0 ? RESP : WAIT) : (resp_ready ? IDLE : RESP);
    cnt_d = state_q == IDLE ? CW'(LATENCY - 1) : cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
  end
  // Control state and response registers; response holds until the handshake.
  always_ff @(posedge CLK) begin
    if (resetl) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (commit) begin
        rdata_q <= (write_q || oor || mis) ? 64'd0 : mem[idx];
        err_q <= mis;
      end
    end
  end
  // Capture the request on the accepting edge.
  always_ff @(posedge CLK) begin
    if (state_q == IDLE && req_valid) begin
      write_q <= req_write;
      addr_q <= req_addr;
      wdata_q <= req_wdata;
    end
  end
  // Store path: out-of-range and misaligned stores are dropped.
  always_ff @(posedge CLK) begin
    if (commit && write_q && !oor && !mis) mem[idx] <= wdata_q;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: random stimulus against a word-array reference model, plus a LATENCY=1 instance.
module tb_data_mem_responder;
  localparam int DW = 1024;
  localparam int LAT = 2;
  logic CLK = 1'b0;
  logic resetl;
  logic req_valid, req_write, resp_ready, req_ready, resp_valid, resp_err;
  logic [63:0] req_addr, req_wdata, resp_rdata;
  logic q1_valid, q1_write, q1_rready, q1_ready, q1_rvalid, q1_err;
  logic [63:0] q1_addr, q1_wdata, q1_rdata;
  int total = 0;
  int bad = 0;
  logic [63:0] mdl [longint unsigned];

  always #5 CLK = ~CLK;

  data_mem_responder #(.DEPTH_WORDS(DW), .LATENCY(LAT), .ADDR_W(64)) u0 (
    .CLK(CLK), .resetl(resetl), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err));

  data_mem_responder #(.DEPTH_WORDS(DW), .LATENCY(1), .ADDR_W(64)) u1 (
    .CLK(CLK), .resetl(resetl), .req_valid(q1_valid), .req_ready(q1_ready),
    .req_write(q1_write), .req_addr(q1_addr), .req_wdata(q1_wdata),
    .resp_valid(q1_rvalid), .resp_ready(q1_rready), .resp_rdata(q1_rdata), .resp_err(q1_err));

  function automatic bit is_mis(input logic [63:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return a[2:0] != 3'd0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit in_rng(input logic [63:0] a);
    return a < 64'(DW) * 8;
  endfunction

  function automatic logic [63:0] ld_exp(input logic [63:0] a);
    if (is_mis(a) || !in_rng(a)) return 64'd0;
    return mdl.exists(a >> 3) ? mdl[a >> 3] : 64'bx;
  endfunction

  function automatic void st(input logic [63:0] a, input logic [63:0] d);
    if (!is_mis(a) && in_rng(a)) mdl[a >> 3] = d;
  endfunction

  task automatic xact(input bit wr, input logic [63:0] a, input logic [63:0] d, input int hold,
                      output int lat, output logic [63:0] rd, output logic er, output bit stab, output bit idle_after);
    stab = 1'b1;
    req_write = wr; req_addr = a; req_wdata = d; req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 40) begin
      if (req_ready !== 1'b0) stab = 1'b0;
      @(posedge CLK); #1;
      lat++;
    end
    rd = resp_rdata; er = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== rd || resp_err !== er) stab = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge CLK); #1;
    resp_ready = 1'b0;
    idle_after = req_ready === 1'b1 && resp_valid === 1'b0;
  endtask

  task automatic test_reset();
    resetl = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b want=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b want=0", resp_valid); end
    total++; if (resp_rdata !== 64'd0) begin bad++; $display("FAIL rst_resp_rdata got=%h want=0", resp_rdata); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL rst_resp_err got=%b want=0", resp_err); end
    total++; if (q1_ready !== 1'b1 || q1_rvalid !== 1'b0) begin bad++; $display("FAIL rst_lat1 got ready=%b valid=%b want 1/0", q1_ready, q1_rvalid); end
    resetl = 1'b0;
  endtask

  task automatic test_fill();
    int lat; logic [63:0] rd, d; logic er; bit stab, idl;
    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom};
      st(64'(i) << 3, d);
      xact(1'b1, 64'(i) << 3, d, 0, lat, rd, er, stab, idl);
      total++; if (lat != LAT || rd !== 64'd0 || !idl) begin bad++; $display("FAIL fill[%0d] got lat=%0d rd=%h idle=%b want lat=%0d rd=0 idle=1", i, lat, rd, idl, LAT); end
    end
  endtask

  task automatic test_store_load();
    int lat; logic [63:0] rd; logic er; bit stab, idl;
    st(64'h10, 64'hDEADBEEF_CAFEF00D);
    xact(1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 0, lat, rd, er, stab, idl);
    total++; if (lat != LAT) begin bad++; $display("FAIL store_latency got=%0d want=%0d", lat, LAT); end
    total++; if (rd !== 64'd0) begin bad++; $display("FAIL store_rdata got=%h want=0", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL store_err got=%b want=0", er); end
    total++; if (!stab || !idl) begin bad++; $display("FAIL store_handshake got stab=%b idle=%b want 1/1", stab, idl); end
    xact(1'b0, 64'h10, 64'h0, 0, lat, rd, er, stab, idl);
    total++; if (rd !== 64'hDEADBEEF_CAFEF00D) begin bad++; $display("FAIL load_back got=%h want=deadbeefcafef00d", rd); end
    total++; if (lat != LAT) begin bad++; $display("FAIL load_latency got=%0d want=%0d", lat, LAT); end
  endtask

  task automatic test_backpressure();
    int lat; logic [63:0] rd, d; logic er; bit stab, idl;
    d = {$urandom, $urandom};
    st(64'h18, d);
    xact(1'b1, 64'h18, d, 0, lat, rd, er, stab, idl);
    xact(1'b0, 64'h18, 64'h0, 5, lat, rd, er, stab, idl);
    total++; if (rd !== d) begin bad++; $display("FAIL bp_rdata got=%h want=%h", rd, d); end
    total++; if (!stab) begin bad++; $display("FAIL bp_stable got=0 want=1"); end
    total++; if (!idl) begin bad++; $display("FAIL bp_idle_after got=0 want=1"); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [63:0] rd; logic er; bit stab, idl;
    xact(1'b1, 64'h2000, 64'h1, 0, lat, rd, er, stab, idl);
    total++; if (er !== 1'b0 || lat != LAT) begin bad++; $display("FAIL oor_store got err=%b lat=%0d want 0/%0d", er, lat, LAT); end
    xact(1'b0, 64'h2000, 64'h0, 0, lat, rd, er, stab, idl);
    total++; if (rd !== 64'd0) begin bad++; $display("FAIL oor_load got=%h want=0", rd); end
    xact(1'b0, 64'h0, 64'h0, 0, lat, rd, er, stab, idl);
    total++; if (rd !== ld_exp(64'h0)) begin bad++; $display("FAIL oor_word0 got=%h want=%h", rd, ld_exp(64'h0)); end
    xact(1'b0, 64'h8000_0000_0000_0010, 64'h0, 0, lat, rd, er, stab, idl);
    total++; if (rd !== 64'd0) begin bad++; $display("FAIL oor_high_load got=%h want=0", rd); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [63:0] rd, a, b; logic er; bit stab, idl;
    a = {$urandom, $urandom};
    b = ~a;
    st(64'h20, a);
    xact(1'b1, 64'h20, a, 0, lat, rd, er, stab, idl);
    for (int v = 0; v < 3; v++) begin
      req_write = 1'b1; req_addr = 64'h20; req_wdata = b; req_valid = 1'b1;
      @(posedge CLK); #1;
      req_valid = 1'b0;
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL mid_accept[%0d] got ready=%b want=0", v, req_ready); end
      for (int k = 0; k < v; k++) begin @(posedge CLK); #1; end
      if (v == 2) begin
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL mid_committed_resp got=%b want=1", resp_valid); end
        st(64'h20, b);
      end
      resetl = 1'b1;
      @(posedge CLK); #1;
      resetl = 1'b0;
      total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_state[%0d] got ready=%b valid=%b want 1/0", v, req_ready, resp_valid); end
      xact(1'b0, 64'h20, 64'h0, 0, lat, rd, er, stab, idl);
      total++; if (rd !== ld_exp(64'h20)) begin bad++; $display("FAIL mid_load[%0d] got=%h want=%h", v, rd, ld_exp(64'h20)); end
      b = {$urandom, $urandom};
    end
  endtask

  task automatic test_align();
    int lat; logic [63:0] rd, x; logic er; bit stab, idl;
    x = {$urandom, $urandom};
    xact(1'b1, 64'h21, x, 0, lat, rd, er, stab, idl);
    total++; if (er !== is_mis(64'h21) || rd !== 64'd0) begin bad++; $display("FAIL align_store_err got err=%b rd=%h want %b/0", er, rd, is_mis(64'h21)); end
    st(64'h21, x);
    xact(1'b0, 64'h20, 64'h0, 0, lat, rd, er, stab, idl);
    total++; if (rd !== ld_exp(64'h20)) begin bad++; $display("FAIL align_mem got=%h want=%h", rd, ld_exp(64'h20)); end
    xact(1'b1, 64'h20, ~x, 0, lat, rd, er, stab, idl);
    st(64'h20, ~x);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL align_ok_err got=%b want=0", er); end
  endtask

  task automatic test_random();
    int lat, hold; logic [63:0] rd, a, d, e; logic er; bit stab, idl, wr;
    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom_range(0, 1));
      a = 64'($urandom_range(0, 15)) << 3;
      if ($urandom_range(0, 5) == 0) a = a | 64'($urandom_range(1, 7));
      if ($urandom_range(0, 7) == 0) a = a | (64'd1 << $urandom_range(13, 63));
      d = {$urandom, $urandom};
      hold = $urandom_range(0, 3);
      e = wr ? 64'd0 : ld_exp(a);
      xact(wr, a, d, hold, lat, rd, er, stab, idl);
      if (wr) st(a, d);
      total++; if (lat != LAT || !stab || !idl) begin bad++; $display("FAIL rnd_timing[%0d] a=%h got lat=%0d stab=%b idle=%b want %0d/1/1", n, a, lat, stab, idl, LAT); end
      total++; if (er !== is_mis(a)) begin bad++; $display("FAIL rnd_err[%0d] a=%h got=%b want=%b", n, a, er, is_mis(a)); end
      if (!$isunknown(e)) begin
        total++; if (rd !== e) begin bad++; $display("FAIL rnd_rdata[%0d] a=%h got=%h want=%h", n, a, rd, e); end
      end
    end
  endtask

  task automatic test_lat1_back_to_back();
    logic [63:0] v;
    v = {$urandom, $urandom};
    q1_valid = 1'b1; q1_write = 1'b1; q1_addr = 64'h40; q1_wdata = v; q1_rready = 1'b1;
    total++; if (q1_ready !== 1'b1) begin bad++; $display("FAIL l1_pre_ready got=%b want=1", q1_ready); end
    @(posedge CLK); #1;
    total++; if (q1_ready !== 1'b0 || q1_rvalid !== 1'b0) begin bad++; $display("FAIL l1_n got ready=%b valid=%b want 0/0", q1_ready, q1_rvalid); end
    q1_write = 1'b0;
    @(posedge CLK); #1;
    total++; if (q1_rvalid !== 1'b1 || q1_rdata !== 64'd0) begin bad++; $display("FAIL l1_n1 got valid=%b rd=%h want 1/0", q1_rvalid, q1_rdata); end
    @(posedge CLK); #1;
    total++; if (q1_rvalid !== 1'b0 || q1_ready !== 1'b1) begin bad++; $display("FAIL l1_n2 got valid=%b ready=%b want 0/1", q1_rvalid, q1_ready); end
    @(posedge CLK); #1;
    q1_valid = 1'b0;
    total++; if (q1_ready !== 1'b0 || q1_rvalid !== 1'b0) begin bad++; $display("FAIL l1_n3 got ready=%b valid=%b want 0/0", q1_ready, q1_rvalid); end
    @(posedge CLK); #1;
    total++; if (q1_rvalid !== 1'b1 || q1_rdata !== v) begin bad++; $display("FAIL l1_n4 got valid=%b rd=%h want 1/%h", q1_rvalid, q1_rdata, v); end
    @(posedge CLK); #1;
    q1_rready = 1'b0;
    total++; if (q1_ready !== 1'b1) begin bad++; $display("FAIL l1_idle got=%b want=1", q1_ready); end
  endtask

  initial begin
    resetl = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    q1_valid = 1'b0; q1_write = 1'b0; q1_addr = '0; q1_wdata = '0; q1_rready = 1'b0;
    test_reset();
    test_fill();
    test_store_load();
    test_backpressure();
    test_out_of_range();
    test_reset_mid();
    test_align();
    test_random();
    test_lat1_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
